// File: rtl/spi_byte_phy.sv
// spi_byte_phy: byte-wide request/response to a 1-bit SPI mode-0 link.
// Owns chip-select setup/hold timing and SCLK generation for one NOR flash.
// Build option: define SPI_PHY_LOOPBACK_EN to sample spi_mosi instead of
// spi_miso (self-test: rx_byte echoes tx_byte).
module spi_byte_phy #(
    parameter int CLK_DIV      = 2,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2
) (
    input  logic       p_clk,
    input  logic       p_reset_n,
    input  logic       cs_req,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       busy,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int CW = 16;
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, READY, SHIFT, HOLD} state_e;

    state_e        state_q;
    logic [CW-1:0] tmr_q;      // setup / hold cycle count
    logic [CW-1:0] div_q;      // SCLK half-period divider
    logic [2:0]    bit_q;      // completed falling edges in this byte
    logic [6:0]    tx_sh_q;    // bits still to go out after the one on MOSI
    logic [7:0]    rx_sh_q;
    logic [7:0]    rx_byte_q;
    logic          rx_valid_q;
    logic          tx_ready_q;
    logic          busy_q;
    logic          cs_n_q;
    logic          sclk_q;
    logic          mosi_q;
    logic          miso_s;

`ifdef SPI_PHY_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign miso_s      = mosi_q;
`else
    assign miso_s      = spi_miso;
`endif

    // Link FSM: all pin and handshake outputs are registered here.
    always_ff @(posedge p_clk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_req) begin
                        state_q <= SETUP;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        tmr_q   <= '0;
                    end
                end
                SETUP: begin
                    if (tmr_q == SETUP_LAST) begin
                        state_q    <= READY;
                        tx_ready_q <= 1'b1;
                        tmr_q      <= '0;
                    end else begin
                        tmr_q <= tmr_q + CW'(1);
                    end
                end
                READY: begin
                    // A pending byte wins over a cs_req drop; the drop is seen on return.
                    if (tx_valid) begin
                        state_q    <= SHIFT;
                        tx_ready_q <= 1'b0;
                        mosi_q     <= tx_byte[7];
                        tx_sh_q    <= tx_byte[6:0];
                        div_q      <= '0;
                        bit_q      <= '0;
                    end else if (!cs_req) begin
                        state_q    <= HOLD;
                        tx_ready_q <= 1'b0;
                        tmr_q      <= '0;
                    end
                end
                SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q  <= 1'b1;
                            rx_sh_q <= {rx_sh_q[6:0], miso_s};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == 3'd7) begin
                                // Last fall: hand the byte back and reopen the request side.
                                bit_q      <= '0;
                                rx_byte_q  <= rx_sh_q;
                                rx_valid_q <= 1'b1;
                                tx_ready_q <= 1'b1;
                                state_q    <= READY;
                            end else begin
                                bit_q   <= bit_q + 3'd1;
                                mosi_q  <= tx_sh_q[6];
                                tx_sh_q <= {tx_sh_q[5:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (tmr_q == HOLD_LAST) begin
                        state_q <= IDLE;
                        cs_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;

endmodule
